fir_cfg_master: RTL and testbench
=================================

// Module: fir_cfg_master
// PURPOSE
//   AXI-Lite master that sits directly upstream of the fir block's config port.
//   On a start pulse it:
//     - writes data_length to 0x34,
//     - writes pTAP_NUM coefficients to 0x00 + 4*k,
//     - optionally reads them back to verify,
//     - writes ap_start (0x30 = 1),
//     - polls 0x30 until ap_done (bit 1) is set.
//   Replaces bench-driven configuration so a system-level controller can run the FIR.
// PARAMETERS
//   pADDR_WIDTH  12  AXI-Lite address width
//   pDATA_WIDTH  32  AXI-Lite data width; coefficient width
//   pTAP_NUM     11  coefficients written per run
//   pPOLL_GAP    8   idle cycles between successive status-poll reads (>=1)
// PORTS
//   axis_clk     in   1                    clock
//   axis_rst_n   in   1                    asynchronous active-low reset
//   start        in   1                    1-cycle pulse; begin sequence (ignored while busy)
//   verify_en    in   1                    sampled at start; 1 = read back taps after writing
//   data_length  in   32                   sampled at start; value written to 0x34
//   coef_flat    in   pTAP_NUM*pDATA_WIDTH sampled at start; tap k = coef_flat[32k+:32]
//   busy         out  1                    high from accepted start until done
//   done         out  1                    level; set at end of sequence, cleared by next accepted start
//   cfg_err      out  1                    level; readback mismatch in this run, cleared by next start
//   awvalid      out  1                    write address valid
//   awready      in   1                    write address ready
//   awaddr       out  pADDR_WIDTH          write address
//   wvalid       out  1                    write data valid
//   wready       in   1                    write data ready
//   wdata        out  pDATA_WIDTH          write data
//   arvalid      out  1                    read address valid
//   arready      in   1                    read address ready
//   araddr       out  pADDR_WIDTH          read address
//   rvalid       in   1                    read data valid
//   rready       out  1                    read data ready
//   rdata        in   pDATA_WIDTH          read data
// BEHAVIOUR
//   Reset:
//     - All outputs 0; state IDLE; internal tap index 0.
//     - Reset asserted mid-sequence aborts immediately: no partial handshake is completed
//       and outputs go to 0 asynchronously.
//   States: IDLE -> WR_LEN -> WR_TAP -> (RD_TAP if verify_en) -> WR_START -> POLL_RD <-> POLL_WAIT -> DONE.
//     - IDLE: on start, latch the inputs, set busy=1, clear done and cfg_err, go to WR_LEN.
//       Start seen in any other state is ignored.
//   Write transaction (WR_LEN, WR_TAP k = 0..pTAP_NUM-1, WR_START):
//     - Drive awvalid=1 and wvalid=1 in the same cycle, with awaddr and wdata stable.
//     - Each valid drops the cycle after its own ready is sampled high.
//     - Handshakes may complete in either order or together.
//     - The transaction is complete once both are done; the next transaction starts the
//       following cycle. No B channel exists.
//     - WR_LEN:   addr 0x34, data = data_length.
//     - WR_TAP:   addr 4*k,  data = tap k.
//     - WR_START: addr 0x30, data = 0x0000_0001.
//   Read transaction (RD_TAP, POLL_RD):
//     - arvalid=1 with araddr until arready is sampled high, then arvalid=0.
//     - rready=1 from the cycle after AR is accepted until rvalid is sampled high.
//     - rdata is captured in the rvalid&rready cycle.
//     - An rvalid arriving in the same cycle as arready is not accepted; it must be
//       held until rready is asserted.
//   RD_TAP:
//     - Read address 4*k for k = 0..pTAP_NUM-1.
//     - On mismatch: cfg_err=1, skip the remaining reads and WR_START, go to DONE.
//   POLL_RD:
//     - Read 0x30.
//     - If rdata[1]=1, go to DONE.
//     - Otherwise go to POLL_WAIT for pPOLL_GAP cycles, then return to POLL_RD.
//     - No timeout.
//   DONE: busy=0, done=1 (held), return to IDLE the same cycle.
//   Timing:
//     - At most one outstanding AXI-Lite transaction; reads and writes never overlap.
//     - Minimum latency with ready tied high: 2 cycles per write, 3 per read.
// TESTING
//   1. ready tied high, verify_en=0, taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, length 600
//      -> writes in order 0x34=600, 0x00..0x28 = taps, 0x30=1;
//         polls 0x30; done=1 after slave returns bit1.
//   2. wready delayed 3 cycles vs awready (and the reverse case)
//      -> each valid drops independently; no duplicate or skipped write; wdata stable while wvalid.
//   3. verify_en=1, slave returns tap 5 = 62 instead of 63
//      -> cfg_err=1, done=1, no write to 0x30, no reads of taps 6..10.
//   4. status returns 0x04 for 4 polls, then 0x06
//      -> exactly 5 reads of 0x30, spaced pPOLL_GAP idle cycles apart; then done=1, busy=0.
//   5. start pulsed while busy; reset asserted during WR_TAP k=4
//      -> extra start ignored; on reset all outputs 0 immediately;
//         a new start replays the full sequence from 0x34.

Source files
------------

// File: rtl/fir_cfg_master.sv
// rtl/fir_cfg_master.sv - AXI-Lite master that loads length/taps into the fir, optionally verifies, starts it and polls for done
module fir_cfg_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTAP_NUM    = 11,
    parameter int pPOLL_GAP   = 8
) (
    input  logic                            axis_clk,
    input  logic                            axis_rst_n,
    input  logic                            start,
    input  logic                            verify_en,
    input  logic [31:0]                     data_length,
    input  logic [pTAP_NUM*pDATA_WIDTH-1:0] coef_flat,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err,
    output logic                            awvalid,
    input  logic                            awready,
    output logic [pADDR_WIDTH-1:0]          awaddr,
    output logic                            wvalid,
    input  logic                            wready,
    output logic [pDATA_WIDTH-1:0]          wdata,
    output logic                            arvalid,
    input  logic                            arready,
    output logic [pADDR_WIDTH-1:0]          araddr,
    input  logic                            rvalid,
    output logic                            rready,
    input  logic [pDATA_WIDTH-1:0]          rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_LEN    = 3'd1;
    localparam logic [2:0] S_WR_TAP    = 3'd2;
    localparam logic [2:0] S_RD_TAP    = 3'd3;
    localparam logic [2:0] S_WR_START  = 3'd4;
    localparam logic [2:0] S_POLL_RD   = 3'd5;
    localparam logic [2:0] S_POLL_WAIT = 3'd6;

    localparam int IDX_W = $clog2(pTAP_NUM + 1);
    localparam int GAP_W = $clog2(pPOLL_GAP + 1);
    localparam logic [IDX_W-1:0]       LAST_TAP  = IDX_W'(pTAP_NUM - 1);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(12'h030);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(12'h034);

    logic [2:0]                      state;
    logic [1:0]                      phase;
    logic [IDX_W-1:0]                tap_idx;
    logic [GAP_W-1:0]                gap_cnt;
    logic                            verify_q;
    logic [31:0]                     len_q;
    logic [pTAP_NUM*pDATA_WIDTH-1:0] coef_q;

    logic [pDATA_WIDTH-1:0] cur_tap;
    logic [pADDR_WIDTH-1:0] tap_addr;
    logic [pADDR_WIDTH-1:0] wr_addr;
    logic [pADDR_WIDTH-1:0] rd_addr;
    logic [pDATA_WIDTH-1:0] wr_data;
    logic                   last_tap;

    assign cur_tap  = coef_q[int'(tap_idx)*pDATA_WIDTH +: pDATA_WIDTH];
    assign tap_addr = pADDR_WIDTH'({tap_idx, 2'b00});
    assign last_tap = (tap_idx == LAST_TAP);
    assign rd_addr  = (state == S_POLL_RD) ? ADDR_CTRL : tap_addr;

    always_comb begin
        wr_addr = tap_addr;
        wr_data = cur_tap;
        case (state)
            S_WR_LEN: begin
                wr_addr = ADDR_LEN;
                wr_data = pDATA_WIDTH'(len_q);
            end
            S_WR_START: begin
                wr_addr = ADDR_CTRL;
                wr_data = pDATA_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // phase 0 presents the request, phase 1 waits on address/data handshakes, phase 2 waits on R
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state    <= S_IDLE;
            phase    <= 2'd0;
            tap_idx  <= '0;
            gap_cnt  <= '0;
            verify_q <= 1'b0;
            len_q    <= '0;
            coef_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            awvalid  <= 1'b0;
            awaddr   <= '0;
            wvalid   <= 1'b0;
            wdata    <= '0;
            arvalid  <= 1'b0;
            araddr   <= '0;
            rready   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        verify_q <= verify_en;
                        len_q    <= data_length;
                        coef_q   <= coef_flat;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        cfg_err  <= 1'b0;
                        tap_idx  <= '0;
                        phase    <= 2'd0;
                        state    <= S_WR_LEN;
                    end
                end
                S_WR_LEN, S_WR_TAP, S_WR_START: begin
                    if (phase == 2'd0) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        awaddr  <= wr_addr;
                        wdata   <= wr_data;
                        phase   <= 2'd1;
                    end else begin
                        if (awvalid && awready) awvalid <= 1'b0;
                        if (wvalid && wready)   wvalid  <= 1'b0;
                        if ((!awvalid || awready) && (!wvalid || wready)) begin
                            phase <= 2'd0;
                            if (state == S_WR_LEN) begin
                                state <= S_WR_TAP;
                            end else if (state == S_WR_START) begin
                                state <= S_POLL_RD;
                            end else if (last_tap) begin
                                tap_idx <= '0;
                                state   <= verify_q ? S_RD_TAP : S_WR_START;
                            end else begin
                                tap_idx <= tap_idx + 1'b1;
                            end
                        end
                    end
                end
                S_RD_TAP, S_POLL_RD: begin
                    if (phase == 2'd0) begin
                        arvalid <= 1'b1;
                        araddr  <= rd_addr;
                        phase   <= 2'd1;
                    end else if (phase == 2'd1) begin
                        if (arready) begin
                            arvalid <= 1'b0;
                            rready  <= 1'b1;
                            phase   <= 2'd2;
                        end
                    end else if (rvalid) begin
                        rready <= 1'b0;
                        phase  <= 2'd0;
                        if (state == S_POLL_RD) begin
                            if (rdata[1]) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                gap_cnt <= GAP_W'(pPOLL_GAP - 1);
                                state   <= S_POLL_WAIT;
                            end
                        end else if (rdata != cur_tap) begin
                            cfg_err <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else if (last_tap) begin
                            state <= S_WR_START;
                        end else begin
                            tap_idx <= tap_idx + 1'b1;
                        end
                    end
                end
                S_POLL_WAIT: begin
                    // issue the next poll directly so exactly pPOLL_GAP idle cycles separate reads
                    if (gap_cnt == '0) begin
                        arvalid <= 1'b1;
                        araddr  <= ADDR_CTRL;
                        phase   <= 2'd1;
                        state   <= S_POLL_RD;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_cfg_master.sv
// tb/tb_fir_cfg_master.sv - self-checking bench for fir_cfg_master against a transaction-list model
module tb_fir_cfg_master;

    localparam int NT  = 11;
    localparam int GAP = 8;

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
    } tx_t;

    logic             axis_clk = 1'b0;
    logic             axis_rst_n = 1'b0;
    logic             start = 1'b0;
    logic             verify_en = 1'b0;
    logic [31:0]      data_length = '0;
    logic [NT*32-1:0] coef_flat = '0;
    logic             busy, done, cfg_err;
    logic             awvalid, wvalid, arvalid, rready;
    logic [11:0]      awaddr, araddr;
    logic [31:0]      wdata;
    logic             awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0]      rdata = '0;

    fir_cfg_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTAP_NUM(NT), .pPOLL_GAP(GAP)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .verify_en(verify_en),
        .data_length(data_length), .coef_flat(coef_flat), .busy(busy), .done(done), .cfg_err(cfg_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .wvalid(wvalid), .wready(wready),
        .wdata(wdata), .arvalid(arvalid), .arready(arready), .araddr(araddr), .rvalid(rvalid),
        .rready(rready), .rdata(rdata)
    );

    always #5 axis_clk = ~axis_clk;

    int taps[NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration
    int  aw_dly = 0, w_dly = 0, busy_polls = 0, poll_cnt = 0, bad_idx = -1;
    bit  early_r = 1'b0;

    // model and monitor state
    tx_t         exp_q[64];
    int          exp_n = 0, exp_i = 0;
    bit          mon_en = 1'b0, fast = 1'b0;
    logic [11:0] obs_addr[32];
    logic [31:0] obs_data[32];
    int          n_obs = 0, n_reads = 0, n_polls = 0;
    int          cyc = 0, last_aw = -1, last_poll = -1;
    bit          aw_got = 1'b0, w_got = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic slave_resp(input logic [11:0] a, output logic [31:0] d);
        if (a == 12'h030) begin
            d = (poll_cnt < busy_polls) ? 32'h4 : 32'h6;
            poll_cnt++;
        end else if (int'(a >> 2) == bad_idx) begin
            d = 32'(taps[bad_idx]) - 32'd1;
        end else begin
            d = 32'(taps[int'(a >> 2)]);
        end
    endtask

    // AXI-Lite slave: ready/valid decisions made just after each clock edge
    initial begin
        bit          s_ar_fire, s_r_fire, rd_pend;
        logic [11:0] s_araddr, rd_a;
        int          aw_cnt, w_cnt;
        logic [31:0] d;
        rd_pend = 0; aw_cnt = 0; w_cnt = 0; rd_a = '0;
        forever begin
            @(negedge axis_clk);
            s_ar_fire = arvalid && arready;
            s_r_fire  = rvalid && rready;
            s_araddr  = araddr;
            @(posedge axis_clk);
            #1;
            if (!axis_rst_n) begin
                awready = 0; wready = 0; arready = 0; rvalid = 0;
                rd_pend = 0; aw_cnt = 0; w_cnt = 0;
                continue;
            end
            if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (s_r_fire) rvalid = 0;
            if (s_ar_fire && !rvalid) begin rd_pend = 1; rd_a = s_araddr; end
            arready = arvalid;
            if (!rvalid) begin
                if (rd_pend) begin
                    slave_resp(rd_a, d); rdata = d; rvalid = 1; rd_pend = 0;
                end else if (early_r && arvalid) begin
                    slave_resp(araddr, d); rdata = d; rvalid = 1;
                end
            end
        end
    end

    // compare process: every channel beat is checked against the head of the expected list
    initial begin
        logic [11:0] rd_a;
        bit          prev_ar;
        tx_t         head;
        rd_a = '0; prev_ar = 0;
        forever begin
            @(negedge axis_clk);
            cyc++;
            if (!axis_rst_n || !mon_en) begin prev_ar = 0; continue; end
            if (awvalid || wvalid || arvalid || rready) begin
                chk("busy_during_tx", {31'd0, busy}, 32'd1);
                chk("rd_wr_overlap", {31'd0, (awvalid || wvalid) && (arvalid || rready)}, 32'd0);
                if (exp_i >= exp_n) begin
                    chk("extra_tx", 32'(exp_i), 32'(exp_n - 1));
                end else begin
                    head = exp_q[exp_i];
                    if (awvalid) begin
                        chk("aw_is_write", {31'd0, head.wr}, 32'd1);
                        chk("awaddr", {20'd0, awaddr}, {20'd0, head.addr});
                    end
                    if (wvalid) begin
                        chk("w_is_write", {31'd0, head.wr}, 32'd1);
                        chk("wdata", wdata, head.data);
                    end
                    if (arvalid) begin
                        chk("ar_is_read", {31'd0, head.wr}, 32'd0);
                        chk("araddr", {20'd0, araddr}, {20'd0, head.addr});
                    end
                end
            end
            if (arvalid && !prev_ar && araddr == 12'h030 && last_poll >= 0)
                chk("poll_gap", 32'(cyc - last_poll - 1), 32'(GAP));
            prev_ar = arvalid;
            if (awvalid && awready) begin
                if (fast && last_aw >= 0) chk("wr_spacing", 32'(cyc - last_aw), 32'd2);
                last_aw = cyc;
                aw_got = 1;
                if (n_obs < 32) obs_addr[n_obs] = awaddr;
            end
            if (wvalid && wready) begin
                w_got = 1;
                if (n_obs < 32) obs_data[n_obs] = wdata;
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; n_obs++; exp_i++;
            end
            if (arvalid && arready) rd_a = araddr;
            if (rvalid && rready) begin
                n_reads++;
                exp_i++;
                if (rd_a == 12'h030) begin n_polls++; last_poll = cyc; end
            end
        end
    end

    task automatic add_tx(input logic wr, input logic [11:0] a, input logic [31:0] d);
        exp_q[exp_n] = '{wr: wr, addr: a, data: d};
        exp_n++;
    endtask

    task automatic begin_run(input logic [31:0] len, input bit ver, input int bad, input int polls,
                             input int awd, input int wd, input bit er, input bit fst);
        aw_dly = awd; w_dly = wd; early_r = er; busy_polls = polls; poll_cnt = 0; bad_idx = bad;
        fast = fst;
        exp_n = 0; exp_i = 0; n_obs = 0; n_reads = 0; n_polls = 0;
        last_aw = -1; last_poll = -1; aw_got = 0; w_got = 0;
        add_tx(1'b1, 12'h034, len);
        for (int k = 0; k < NT; k++) add_tx(1'b1, 12'(4 * k), 32'(taps[k]));
        if (ver) begin
            for (int k = 0; k < NT; k++) begin
                add_tx(1'b0, 12'(4 * k), 32'd0);
                if (k == bad) break;
            end
        end
        if (!(ver && bad >= 0)) begin
            add_tx(1'b1, 12'h030, 32'd1);
            for (int p = 0; p <= polls; p++) add_tx(1'b0, 12'h030, 32'd0);
        end
        mon_en = 1;
        @(negedge axis_clk);
        verify_en = ver; data_length = len;
        for (int k = 0; k < NT; k++) coef_flat[32*k +: 32] = 32'(taps[k]);
        start = 1;
        @(negedge axis_clk);
        start = 0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("err_cleared", {31'd0, cfg_err}, 32'd0);
    endtask

    task automatic finish_run(input bit exp_err);
        int i;
        for (i = 0; i < 4000 && !done; i++) @(negedge axis_clk);
        chk("done_within_budget", {31'd0, done}, 32'd1);
        chk("busy_at_end", {31'd0, busy}, 32'd0);
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
        chk("all_tx_seen", 32'(exp_i), 32'(exp_n));
        repeat (3) @(negedge axis_clk);
        chk("done_held", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int i;
        repeat (3) @(negedge axis_clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
        axis_rst_n = 1;
        repeat (2) @(negedge axis_clk);

        // ready tied high, no verify, two busy polls
        begin_run(32'd600, 0, -1, 2, 0, 0, 0, 1);
        finish_run(0);
        chk("t1_writes", 32'(n_obs), 32'd13);
        chk("t1_len_addr", {20'd0, obs_addr[0]}, 32'h034);
        chk("t1_len_data", obs_data[0], 32'd600);
        chk("t1_tap1_addr", {20'd0, obs_addr[2]}, 32'h004);
        chk("t1_tap1_data", obs_data[2], 32'hFFFF_FFF6);
        chk("t1_tap5_data", obs_data[6], 32'd63);
        chk("t1_start_addr", {20'd0, obs_addr[12]}, 32'h030);
        chk("t1_start_data", obs_data[12], 32'd1);
        chk("t1_polls", 32'(n_polls), 32'd3);

        // skewed ready: data late, then address late
        begin_run(32'd100, 0, -1, 0, 0, 3, 0, 0);
        finish_run(0);
        chk("t2a_writes", 32'(n_obs), 32'd13);
        begin_run(32'd101, 0, -1, 0, 3, 0, 0, 0);
        finish_run(0);
        chk("t2b_writes", 32'(n_obs), 32'd13);

        // readback mismatch at tap 5
        begin_run(32'd600, 1, 5, 0, 0, 0, 1, 0);
        finish_run(1);
        chk("t3_writes", 32'(n_obs), 32'd12);
        chk("t3_reads", 32'(n_reads), 32'd6);

        // four busy polls, early rvalid
        begin_run(32'd600, 0, -1, 4, 1, 1, 1, 0);
        finish_run(0);
        chk("t4_polls", 32'(n_polls), 32'd5);

        // verify passes
        begin_run(32'd7, 1, -1, 0, 0, 0, 0, 0);
        finish_run(0);
        chk("t4b_reads", 32'(n_reads), 32'd12);

        // extra start while busy is ignored
        begin_run(32'd600, 0, -1, 1, 0, 0, 0, 0);
        repeat (3) @(negedge axis_clk);
        data_length = 32'd999; start = 1;
        @(negedge axis_clk);
        start = 0;
        finish_run(0);
        chk("t5_writes", 32'(n_obs), 32'd13);

        // reset during tap 4 write, then full replay
        begin_run(32'd600, 0, -1, 0, 0, 0, 0, 0);
        for (i = 0; i < 200; i++) begin
            if (awvalid && awaddr == 12'h010) break;
            @(negedge axis_clk);
        end
        chk("t5_reach_tap4", {31'd0, awvalid && awaddr == 12'h010}, 32'd1);
        #2;
        axis_rst_n = 0;
        #1;
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
        chk("t5_rst_awaddr", {20'd0, awaddr}, 32'd0);
        chk("t5_rst_wdata", wdata, 32'd0);
        mon_en = 0;
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1;
        @(negedge axis_clk);
        begin_run(32'd600, 0, -1, 0, 0, 0, 0, 0);
        finish_run(0);
        chk("t5_replay_len_addr", {20'd0, obs_addr[0]}, 32'h034);
        chk("t5_replay_writes", 32'(n_obs), 32'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
